// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA/TFT test-pattern scheduler:
//   - state_t     : backlight sequencing states
//   - PWM_W       : width of the backlight duty / PWM counter
//   - BLACK/WHITE : common RGB888 constants
//   - bar_colour(): the eight colour-bar RGB888 values, indexed 0..7
// ----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2,
    SWITCH   = 2'd3
  } state_t;

  localparam int PWM_W = 8;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  localparam logic [23:0] BAR_0 = 24'hFFFFFF;  // white
  localparam logic [23:0] BAR_1 = 24'hFFFF00;  // yellow
  localparam logic [23:0] BAR_2 = 24'h00FFFF;  // cyan
  localparam logic [23:0] BAR_3 = 24'h00FF00;  // green
  localparam logic [23:0] BAR_4 = 24'hFF00FF;  // magenta
  localparam logic [23:0] BAR_5 = 24'hFF0000;  // red
  localparam logic [23:0] BAR_6 = 24'h0000FF;  // blue
  localparam logic [23:0] BAR_7 = 24'h000000;  // black

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_0;
      3'd1:    return BAR_1;
      3'd2:    return BAR_2;
      3'd3:    return BAR_3;
      3'd4:    return BAR_4;
      3'd5:    return BAR_5;
      3'd6:    return BAR_6;
      default: return BAR_7;
    endcase
  endfunction

endpackage

// File: rtl/bl_pwm.sv
// ----------------------------------------------------------------------------
// bl_pwm
//   Backlight PWM. A free-running PWM_W-bit counter is compared against the
//   requested duty; full-scale duty forces the output permanently high so a
//   "fully on" backlight has no periodic low cycle.
// Ports:
//   Clk    in   pixel clock
//   Reset  in   asynchronous, active-high reset
//   Duty   in   PWM_W-bit duty (0 = off, all-ones = constant on)
//   TFT_BL out  registered backlight PWM
// ----------------------------------------------------------------------------
module bl_pwm
  import vga_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PWM_W-1:0] Duty,
  output logic             TFT_BL
);

  logic [PWM_W-1:0] pwm_cnt;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its inputs, regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pwm_cnt <= '0;
      TFT_BL  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      TFT_BL  <= (Duty == '1) ? 1'b1 : (pwm_cnt < Duty);
    end
  end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// ----------------------------------------------------------------------------
// vga_pattern_scheduler
//   Supplies RGB888 test-pattern pixels to the VGA/TFT timing generator and
//   sequences the backlight: each pattern is faded in, held, faded out, then
//   the next pattern is selected. All sequencing happens on Frame_Begin so the
//   pattern never changes mid-frame; Next_Req skips ahead to the fade-out.
// Ports:
//   Clk          in   pixel clock
//   Reset        in   asynchronous, active-high reset
//   Frame_Begin  in   one-cycle pulse at start of frame
//   Data_Req     in   pixel request for (H_Addr, V_Addr)
//   H_Addr       in   active column
//   V_Addr       in   active row
//   Next_Req     in   one-cycle pulse: skip to next pattern
//   Disp_Data    out  registered RGB888 pixel, one cycle after the request
//   TFT_BL       out  backlight PWM
//   Pattern_Id   out  current pattern index
//   Busy_Fade    out  high while fading in or out
// ----------------------------------------------------------------------------
module vga_pattern_scheduler
  import vga_pkg::*;
#(
  parameter int H_PIXELS     = 800,
  parameter int V_PIXELS     = 480,
  parameter int HOLD_FRAMES  = 120,
  parameter int FADE_STEP    = 8,
  parameter int NUM_PATTERNS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Frame_Begin,
  input  logic        Data_Req,
  input  logic [11:0] H_Addr,
  input  logic [11:0] V_Addr,
  input  logic        Next_Req,
  output logic [23:0] Disp_Data,
  output logic        TFT_BL,
  output logic [1:0]  Pattern_Id,
  output logic        Busy_Fade
);

  localparam int               HC_W      = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_FRAMES - 1);
  localparam logic [PWM_W-1:0] STEP      = PWM_W'(FADE_STEP);
  localparam logic [1:0]       LAST_PAT  = 2'(NUM_PATTERNS - 1);

  state_t           state, state_nxt;
  logic [PWM_W-1:0] duty, duty_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [1:0]       pat_nxt;
  logic [PWM_W:0]   duty_up;

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  assign duty_up = {1'b0, duty} + {1'b0, STEP};

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    duty_nxt     = duty;
    hold_cnt_nxt = hold_cnt;
    pat_nxt      = Pattern_Id;
    // Skip request outranks a coincident Frame_Begin: the duty is kept and
    // the fade-out starts from wherever the fade-in/hold had reached.
    if (Next_Req && (state == FADE_IN || state == HOLD)) begin
      state_nxt    = FADE_OUT;
      hold_cnt_nxt = '0;
    end else if (Frame_Begin) begin
      case (state)
        FADE_IN: begin
          duty_nxt = duty_up[PWM_W] ? '1 : duty_up[PWM_W-1:0];
          if (duty_nxt == '1) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt    = FADE_OUT;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
        FADE_OUT: begin
          duty_nxt = (duty <= STEP) ? '0 : duty - STEP;
          if (duty_nxt == '0) state_nxt = SWITCH;
        end
        SWITCH: begin
          pat_nxt   = (Pattern_Id == LAST_PAT) ? 2'd0 : Pattern_Id + 2'd1;
          state_nxt = FADE_IN;
        end
        default: state_nxt = FADE_IN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= FADE_IN;
      duty       <= '0;
      hold_cnt   <= '0;
      Pattern_Id <= 2'd0;
      Busy_Fade  <= 1'b1;
    end else begin
      state      <= state_nxt;
      duty       <= duty_nxt;
      hold_cnt   <= hold_cnt_nxt;
      Pattern_Id <= pat_nxt;
      Busy_Fade  <= (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
    end
  end

  // --------------------------------------------------------------------------
  // Pixel generation (uses the registered Pattern_Id, so the picture flips
  // on the same edge that Pattern_Id does)
  // --------------------------------------------------------------------------
  logic [31:0] bar_full;
  logic [2:0]  bar_idx;
  logic [23:0] pix;

  assign bar_full = ({20'd0, H_Addr} * 32'd8) / 32'(H_PIXELS);
  assign bar_idx  = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];

  always_comb begin
    pix = BLACK;
    case (Pattern_Id)
      2'd0: pix = bar_colour(bar_idx);
      2'd1: pix = {3{H_Addr[7:0]}};
      2'd2: pix = (H_Addr[5] ^ V_Addr[5]) ? WHITE : BLACK;
      2'd3: pix = (H_Addr == 12'(0) || H_Addr == 12'(H_PIXELS - 1) ||
                   V_Addr == 12'(0) || V_Addr == 12'(V_PIXELS - 1)) ? WHITE : BLACK;
      default: pix = BLACK;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Disp_Data <= BLACK;
    else       Disp_Data <= Data_Req ? pix : BLACK;
  end

  // --------------------------------------------------------------------------
  // Backlight
  // --------------------------------------------------------------------------
  bl_pwm u_bl_pwm (
    .Clk    (Clk),
    .Reset  (Reset),
    .Duty   (duty),
    .TFT_BL (TFT_BL)
  );

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vga_pattern_scheduler
//   Self-checking bench: table-driven pixel vectors, hand-written backlight
//   sequences, and randomized frame/skip/pixel stimulus compared against a
//   behavioural model of the pattern/backlight rules. Duty is observed from
//   TFT_BL by counting high cycles over one full 256-cycle PWM period.
// ----------------------------------------------------------------------------
module tb_vga_pattern_scheduler;

  localparam int HP   = 800;
  localparam int VP   = 480;
  localparam int HOLD = 2;
  localparam int STEP = 128;

  logic        Clk, Reset, Frame_Begin, Data_Req, Next_Req;
  logic [11:0] H_Addr, V_Addr;
  logic [23:0] Disp_Data;
  logic        TFT_BL;
  logic [1:0]  Pattern_Id;
  logic        Busy_Fade;

  vga_pattern_scheduler #(
    .H_PIXELS    (HP),
    .V_PIXELS    (VP),
    .HOLD_FRAMES (HOLD),
    .FADE_STEP   (STEP),
    .NUM_PATTERNS(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Frame_Begin(Frame_Begin),
    .Data_Req   (Data_Req),
    .H_Addr     (H_Addr),
    .V_Addr     (V_Addr),
    .Next_Req   (Next_Req),
    .Disp_Data  (Disp_Data),
    .TFT_BL     (TFT_BL),
    .Pattern_Id (Pattern_Id),
    .Busy_Fade  (Busy_Fade)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: brightness phase, duty level, frames held, pattern
  // --------------------------------------------------------------------------
  typedef enum {PH_RISE, PH_FULL, PH_FALL, PH_NEXT} phase_t;
  phase_t m_phase;
  int     m_duty, m_held, m_pat;

  task automatic model_reset();
    m_phase = PH_RISE; m_duty = 0; m_held = 0; m_pat = 0;
  endtask

  task automatic model_cycle(input bit fb, input bit nr);
    if (nr && (m_phase == PH_RISE || m_phase == PH_FULL)) begin
      m_phase = PH_FALL; m_held = 0;
    end else if (fb) begin
      if (m_phase == PH_RISE) begin
        m_duty = (m_duty + STEP > 255) ? 255 : m_duty + STEP;
        if (m_duty == 255) begin m_phase = PH_FULL; m_held = 0; end
      end else if (m_phase == PH_FULL) begin
        m_held++;
        if (m_held == HOLD) begin m_phase = PH_FALL; m_held = 0; end
      end else if (m_phase == PH_FALL) begin
        m_duty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
        if (m_duty == 0) m_phase = PH_NEXT;
      end else begin
        m_pat = (m_pat + 1) % 4;
        m_phase = PH_RISE;
      end
    end
  endtask

  function automatic logic [23:0] model_pixel(input int pat, input bit req, input int h, input int v);
    int bar;
    logic [7:0] lvl;
    if (!req) return 24'h000000;
    case (pat)
      0: begin
        bar = 0;
        for (int k = 1; k < 8; k++) if (h * 8 >= k * HP) bar = k;
        case (bar)
          0: return 24'hFFFFFF; 1: return 24'hFFFF00;
          2: return 24'h00FFFF; 3: return 24'h00FF00;
          4: return 24'hFF00FF; 5: return 24'hFF0000;
          6: return 24'h0000FF; default: return 24'h000000;
        endcase
      end
      1: begin lvl = 8'(h % 256); return {lvl, lvl, lvl}; end
      2: return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return (h == 0 || h == HP - 1 || v == 0 || v == VP - 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change and outputs are sampled 1 ns after posedge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic cycle(input bit fb, input bit nr);
    Frame_Begin = fb; Next_Req = nr;
    tick();
    Frame_Begin = 1'b0; Next_Req = 1'b0;
    model_cycle(fb, nr);
    check("pattern_id", 32'(Pattern_Id), 32'(m_pat));
    check("busy_fade", 32'(Busy_Fade), 32'(m_phase == PH_RISE || m_phase == PH_FALL));
  endtask

  task automatic measure_duty(input string name);
    int highs;
    highs = 0;
    tick(); tick();
    for (int i = 0; i < 256; i++) begin
      if (TFT_BL) highs++;
      tick();
    end
    check(name, 32'(highs), 32'((m_duty == 255) ? 256 : m_duty));
  endtask

  task automatic pixel(input bit req, input int h, input int v, input logic [23:0] exp, input string name);
    Data_Req = req; H_Addr = 12'(h); V_Addr = 12'(v);
    tick();
    Data_Req = 1'b0;
    check(name, 32'(Disp_Data), 32'(exp));
  endtask

  typedef struct {
    bit          req;
    int          pat;
    int          h;
    int          v;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic run_pixels(input int pat);
    int h, v;
    bit req;
    foreach (vecs[i])
      if (vecs[i].pat == pat) pixel(vecs[i].req, vecs[i].h, vecs[i].v, vecs[i].exp, "pix_table");
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(0, HP - 1);
      v = $urandom_range(0, VP - 1);
      req = ($urandom_range(0, 3) != 0);
      pixel(req, h, v, model_pixel(m_pat, req, h, v), "pix_rand");
    end
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    vecs.push_back(vec_t'{1, 0,   0,   0, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 0, 100,   0, 24'hFFFF00});
    vecs.push_back(vec_t'{1, 0, 799,   0, 24'h000000});
    vecs.push_back(vec_t'{1, 0,  99,   5, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 0, 200,   9, 24'h00FFFF});
    vecs.push_back(vec_t'{1, 0, 399,   1, 24'h00FF00});
    vecs.push_back(vec_t'{1, 0, 400,   1, 24'hFF00FF});
    vecs.push_back(vec_t'{1, 0, 500,   2, 24'hFF0000});
    vecs.push_back(vec_t'{1, 0, 650,   3, 24'h0000FF});
    vecs.push_back(vec_t'{0, 0,   0,   0, 24'h000000});
    vecs.push_back(vec_t'{1, 1,   5,   3, 24'h050505});
    vecs.push_back(vec_t'{1, 1, 255,   0, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 1, 256,   0, 24'h000000});
    vecs.push_back(vec_t'{1, 1, 300,   7, 24'h2C2C2C});
    vecs.push_back(vec_t'{1, 2,  31,   0, 24'h000000});
    vecs.push_back(vec_t'{1, 2,  32,   0, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 2,  32,  32, 24'h000000});
    vecs.push_back(vec_t'{1, 2,   0,  32, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 3,   0, 100, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 3, 799,   5, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 3, 400,   0, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 3, 400, 479, 24'hFFFFFF});
    vecs.push_back(vec_t'{1, 3, 400, 240, 24'h000000});
    vecs.push_back(vec_t'{1, 3,   1,   1, 24'h000000});
    vecs.push_back(vec_t'{1, 3, 798, 478, 24'h000000});

    // Reset held 200 ns with a white pixel requested: outputs must stay low.
    Reset = 1'b1; Frame_Begin = 1'b0; Next_Req = 1'b0;
    Data_Req = 1'b1; H_Addr = '0; V_Addr = '0;
    model_reset();
    #200;
    check("rst_disp_data",  32'(Disp_Data),  32'h0);
    check("rst_tft_bl",     32'(TFT_BL),     32'h0);
    check("rst_pattern_id", 32'(Pattern_Id), 32'h0);
    check("rst_busy_fade",  32'(Busy_Fade),  32'h1);
    Data_Req = 1'b0;
    Reset = 1'b0;
    tick();
    measure_duty("duty_reset");

    // Pattern 0 pixels, then one full pattern cycle: duty 128,255,255,255,127,0.
    run_pixels(0);
    for (int f = 0; f < 6; f++) begin
      cycle(1'b1, 1'b0);
      measure_duty("duty_seq");
    end
    cycle(1'b1, 1'b0);          // SWITCH -> pattern 1
    run_pixels(1);

    // Skip in HOLD, coincident with Frame_Begin; repeated skips while fading out.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    measure_duty("duty_hold");
    cycle(1'b1, 1'b1);
    measure_duty("duty_skip_kept");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    measure_duty("duty_skip_ignored");
    cycle(1'b1, 1'b1);
    measure_duty("duty_fall1");
    cycle(1'b1, 1'b1);
    measure_duty("duty_fall0");
    cycle(1'b0, 1'b1);          // ignored in SWITCH
    cycle(1'b1, 1'b0);          // -> pattern 2
    run_pixels(2);

    for (int f = 0; f < 20 && m_pat != 3; f++) cycle(1'b1, 1'b0);
    run_pixels(3);
    for (int f = 0; f < 20 && m_pat != 0; f++) cycle(1'b1, 1'b0);
    check("wrap_pattern_id", 32'(Pattern_Id), 32'h0);

    // Randomized frame / skip traffic.
    for (int it = 0; it < 60; it++) begin
      int h, v;
      bit req;
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
      for (int k = $urandom_range(0, 3); k > 0; k--) cycle(1'b0, 1'b0);
      h = $urandom_range(0, HP - 1);
      v = $urandom_range(0, VP - 1);
      req = ($urandom_range(0, 3) != 0);
      pixel(req, h, v, model_pixel(m_pat, req, h, v), "pix_rand_run");
      if ($urandom_range(0, 5) == 0) measure_duty("duty_rand");
    end

    // Asynchronous reset mid-HOLD on pattern 3 with a white border pixel shown.
    for (int f = 0; f < 60 && !(m_pat == 3 && m_phase == PH_FULL); f++) cycle(1'b1, 1'b0);
    Data_Req = 1'b1; H_Addr = '0; V_Addr = '0;
    tick(); tick(); tick();
    check("pre_rst_disp_data", 32'(Disp_Data), 32'hFFFFFF);
    check("pre_rst_tft_bl",    32'(TFT_BL),    32'h1);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_disp_data",  32'(Disp_Data),  32'h0);
    check("mid_rst_tft_bl",     32'(TFT_BL),     32'h0);
    check("mid_rst_pattern_id", 32'(Pattern_Id), 32'h0);
    check("mid_rst_busy_fade",  32'(Busy_Fade),  32'h1);
    Data_Req = 1'b0;
    tick();
    Reset = 1'b0;
    model_reset();
    measure_duty("duty_after_rst");
    cycle(1'b1, 1'b0);
    measure_duty("duty_after_rst_fade");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
